// File: rtl/sga_pkg.sv
// sga_pkg
// Shared definitions for the snake-game move sequencer.
//   - N_DEF        : position / address width (8x8 field -> 6 bits)
//   - MAX_SIZE_DEF : size at which growth stops when SGA_GROW_CAP_EN is defined
//   - state_t      : move-sequencer state encoding (4 bits, IDLE = 0)
//   - ctrl_t       : bundle of the Moore strobes that depend on state only
//   - decode_ctrl  : maps a state onto its strobe pattern
package sga_pkg;

  localparam int N_DEF        = 6;
  localparam int MAX_SIZE_DEF = 14;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    CHECK      = 4'd1,
    ABORT      = 4'd2,
    LOAD       = 4'd3,
    READ       = 4'd4,
    WRITE      = 4'd5,
    HEAD_WRITE = 4'd6,
    HEAD_READ  = 4'd7,
    HEAD_LATCH = 4'd8,
    DONE       = 4'd9
  } state_t;

  typedef struct packed {
    logic load_ram;
    logic we_ram;
    logic mux_ram;
    logic mux_ram_addres;
    logic register_head;
    logic register_eat_apple;
    logic collided;
    logic done;
    logic busy;
    logic render;
  } ctrl_t;

  // Everything not listed for a state stays low; busy and the RAM address
  // source follow "not IDLE".
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c        = '0;
    c.busy   = (s != IDLE);
    c.render = (s != IDLE);
    case (s)
      CHECK:      c.register_eat_apple = 1'b1;
      ABORT:      c.collided = 1'b1;
      LOAD:       c.load_ram = 1'b1;
      WRITE: begin
        c.we_ram         = 1'b1;
        c.mux_ram        = 1'b1;
        c.mux_ram_addres = 1'b1;
      end
      HEAD_WRITE: c.we_ram = 1'b1;
      HEAD_LATCH: c.register_head = 1'b1;
      DONE:       c.done = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_move_sequencer.sv
// snake_move_sequencer
// Control FSM that sequences one snake move through the datapath: wall check,
// tail-to-head shift of the body RAM, new head write, head register reload and
// growth on apple.
//
// Optional feature macro: SGA_GROW_CAP_EN -- when defined, growth in DONE is
// suppressed once size has reached MAX_SIZE.
//
// Ports:
//   clock              in   system clock
//   restart            in   asynchronous active-high reset
//   start              in   one-cycle move request (ignored while busy)
//   end_move           in   RAM address counter is at zero
//   comeu_maca         in   new head equals apple position
//   wall_collision     in   new head leaves the field
//   size[N-1:0]        in   current snake size
//   load_ram           out  load RAM address counter with size
//   counter_ram        out  decrement RAM address counter
//   we_ram             out  RAM write enable
//   mux_ram            out  RAM data: 1 = RAM q, 0 = new head
//   mux_ram_addres     out  RAM address: 1 = counter+1, 0 = counter
//   mux_ram_render     out  RAM address source: 1 = move path, 0 = render
//   register_head      out  head register enable
//   register_eat_apple out  eat-apple flag register enable
//   count_size         out  increment size counter
//   busy               out  move in progress
//   done               out  one-cycle move-complete pulse
//   collided           out  one-cycle pulse: move aborted by wall collision
module snake_move_sequencer
  import sga_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_SIZE = MAX_SIZE_DEF
) (
  input  logic         clock,
  input  logic         restart,
  input  logic         start,
  input  logic         end_move,
  input  logic         comeu_maca,
  input  logic         wall_collision,
  input  logic [N-1:0] size,
  output logic         load_ram,
  output logic         counter_ram,
  output logic         we_ram,
  output logic         mux_ram,
  output logic         mux_ram_addres,
  output logic         mux_ram_render,
  output logic         register_head,
  output logic         register_eat_apple,
  output logic         count_size,
  output logic         busy,
  output logic         done,
  output logic         collided
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   ate;
  logic   grow;

`ifdef SGA_GROW_CAP_EN
  assign grow = ate && (32'(size) < 32'(MAX_SIZE));
`else
  logic size_unused;
  assign size_unused = ^size;
  assign grow        = ate;
`endif

  // Next-state selection. end_move only matters in WRITE, the apple/wall
  // inputs only in CHECK, and start only in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = CHECK;
      CHECK:      state_next = wall_collision ? ABORT : LOAD;
      ABORT:      state_next = IDLE;
      LOAD:       state_next = READ;
      READ:       state_next = WRITE;
      WRITE:      state_next = end_move ? HEAD_WRITE : READ;
      HEAD_WRITE: state_next = HEAD_READ;
      HEAD_READ:  state_next = HEAD_LATCH;
      HEAD_LATCH: state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // State plus registered strobes: outputs are decoded from the state being
  // entered so they line up with that state's cycle without a decode delay.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state      <= IDLE;
      ctrl_q     <= '0;
      ate        <= 1'b0;
      count_size <= 1'b0;
    end else begin
      state      <= state_next;
      ctrl_q     <= decode_ctrl(state_next);
      count_size <= (state_next == DONE) && grow;
      if (state == CHECK) ate <= comeu_maca;
    end
  end

  // The decrement depends on end_move seen during WRITE itself, so it is
  // decoded combinationally from the registered state.
  assign counter_ram = (state == WRITE) && !end_move;

  assign load_ram           = ctrl_q.load_ram;
  assign we_ram             = ctrl_q.we_ram;
  assign mux_ram            = ctrl_q.mux_ram;
  assign mux_ram_addres     = ctrl_q.mux_ram_addres;
  assign mux_ram_render     = ctrl_q.render;
  assign register_head      = ctrl_q.register_head;
  assign register_eat_apple = ctrl_q.register_eat_apple;
  assign busy               = ctrl_q.busy;
  assign done               = ctrl_q.done;
  assign collided           = ctrl_q.collided;

endmodule

// File: tb/tb_snake_move_sequencer.sv
// tb_snake_move_sequencer
// Bench for snake_move_sequencer. A small datapath (body RAM with registered
// read, address counter, head register, size counter) is wrapped around the
// DUT; a snake-body reference keeps the expected field image. Each issued move
// pushes its expected outcome into a scoreboard, and a monitor pops and
// compares whenever done or collided pulses.
module tb_snake_move_sequencer;
  import sga_pkg::*;

  logic       clock = 1'b0;
  logic       restart, start, end_move, comeu_maca, wall_collision;
  logic [5:0] size;
  logic       load_ram, counter_ram, we_ram, mux_ram, mux_ram_addres;
  logic       mux_ram_render, register_head, register_eat_apple;
  logic       count_size, busy, done, collided;

  snake_move_sequencer dut (
    .clock              (clock),
    .restart            (restart),
    .start              (start),
    .end_move           (end_move),
    .comeu_maca         (comeu_maca),
    .wall_collision     (wall_collision),
    .size               (size),
    .load_ram           (load_ram),
    .counter_ram        (counter_ram),
    .we_ram             (we_ram),
    .mux_ram            (mux_ram),
    .mux_ram_addres     (mux_ram_addres),
    .mux_ram_render     (mux_ram_render),
    .register_head      (register_head),
    .register_eat_apple (register_eat_apple),
    .count_size         (count_size),
    .busy               (busy),
    .done               (done),
    .collided           (collided)
  );

  always #5 clock = ~clock;

  // Datapath around the sequencer
  logic [5:0] ram [64];
  logic [5:0] ram_cnt, q, head_reg, size_reg, new_head, size_val, addr;
  logic       size_wr;
  int         writes = 0;
  int         cyc = 0;

  assign size     = size_reg;
  assign end_move = (ram_cnt == 6'd0);
  assign addr     = mux_ram_addres ? ram_cnt + 6'd1 : ram_cnt;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) ram[i] <= 6'(i * 7 + 3);
      ram_cnt  <= '0;
      q        <= '0;
      head_reg <= '0;
    end else begin
      if (load_ram) ram_cnt <= size_reg;
      else if (counter_ram) ram_cnt <= ram_cnt - 6'd1;
      if (mux_ram_render) q <= ram[addr];
      if (we_ram) begin
        ram[addr] <= mux_ram ? q : new_head;
        writes    <= writes + 1;
      end
      if (register_head) head_reg <= q;
    end
    if (size_wr) size_reg <= size_val;
    else if (count_size) size_reg <= size_reg + 6'd1;
  end

  // Reference model and scoreboard
  typedef struct {
    bit           is_done;
    int           at_cyc;
    bit           cnt;
    logic [5:0]   head;
    int           nwrites;
    logic [383:0] img;
    int           eat_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] mdl_ram [64];
  int         mdl_size;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [383:0] mdl_image();
    logic [383:0] v;
    for (int i = 0; i < 64; i++) v[i*6 +: 6] = mdl_ram[i];
    return v;
  endfunction

  function automatic logic [383:0] ram_image();
    logic [383:0] v;
    for (int i = 0; i < 64; i++) v[i*6 +: 6] = ram[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  // A move of snake length S (entries 0..S) takes 2S+8 cycles to done; a
  // collision leaves the field untouched and reports in cycle 2. E is the cyc
  // value during cycle 1.
  task automatic modelMove(input int e_cyc, input bit apple, input bit coll);
    exp_t        e;
    logic [5:0]  body[$];
    int          s;
    s         = mdl_size;
    e.eat_cyc = e_cyc;
    e.head    = new_head;
    if (coll) begin
      e.is_done = 1'b0;
      e.at_cyc  = e_cyc + 1;
      e.cnt     = 1'b0;
      e.nwrites = 0;
    end else begin
      for (int i = 0; i <= s; i++) body.push_back(mdl_ram[i]);
      body.push_front(new_head);
      for (int i = 0; i < body.size(); i++) mdl_ram[i] = body[i];
      e.is_done = 1'b1;
      e.at_cyc  = e_cyc + 2 * s + 7;
      e.nwrites = s + 2;
`ifdef SGA_GROW_CAP_EN
      e.cnt = apple && (s < MAX_SIZE_DEF);
`else
      e.cnt = apple;
`endif
      if (e.cnt) mdl_size++;
    end
    e.img = mdl_image();
    sb.push_back(e);
  endtask

  // Monitor
  exp_t mon_e;
  int   last_eat = -1;
  int   last_writes = 0;

  always @(negedge clock) begin
    if (register_eat_apple) last_eat = cyc;
    if (done || collided) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_completion", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("kind_done", int'(done), int'(mon_e.is_done));
        checkOutput("completion_cycle", cyc, mon_e.at_cyc);
        checkOutput("count_size", int'(count_size), int'(mon_e.cnt));
        checkOutput("ram_writes", writes - last_writes, mon_e.nwrites);
        checkOutput("eat_flag_cycle", last_eat, mon_e.eat_cyc);
        checks++;
        if (ram_image() !== mon_e.img) begin
          errors++;
          $display("[TB] FAIL ram_image: got %h expected %h", ram_image(), mon_e.img);
        end
        if (mon_e.is_done) checkOutput("head_reg", int'(head_reg), int'(mon_e.head));
        last_writes = writes;
      end
    end
  end

  // Stimulus helpers
  task automatic setSize(input int v);
    @(negedge clock);
    size_wr  = 1'b1;
    size_val = 6'(v);
    @(negedge clock);
    size_wr  = 1'b0;
    mdl_size = v;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      checkOutput({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
    checkOutput({name, "_busy_idle"}, int'(busy), 0);
    checkOutput({name, "_size"}, int'(size_reg), mdl_size);
  endtask

  // One start pulse; the apple/wall inputs are scrambled after CHECK to show
  // that they are sampled only there.
  task automatic applyStimulus(input bit apple, input bit coll, input logic [5:0] head);
    @(negedge clock);
    comeu_maca     = apple;
    wall_collision = coll;
    new_head       = head;
    start          = 1'b1;
    modelMove(cyc + 1, apple, coll);
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_cycle1", int'(busy), 1);
    @(negedge clock);
    comeu_maca     = ~apple;
    wall_collision = ~coll;
    drain("move");
    comeu_maca     = 1'b0;
    wall_collision = 1'b0;
  endtask

  initial begin
    restart        = 1'b1;
    start          = 1'b0;
    comeu_maca     = 1'b0;
    wall_collision = 1'b0;
    new_head       = '0;
    size_wr        = 1'b1;
    size_val       = 6'd3;
    mdl_size       = 3;
    for (int i = 0; i < 64; i++) mdl_ram[i] = 6'(i * 7 + 3);
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs",
                int'({load_ram, counter_ram, we_ram, mux_ram, mux_ram_addres, mux_ram_render,
                      register_head, register_eat_apple, count_size, busy, done, collided}), 0);
    size_wr = 1'b0;
    restart = 1'b0;

    // Reset during READ (cycle 3) at size 3: nothing has been written yet.
    setSize(3);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    restart = 1'b1;
    #1;
    checkOutput("midmove_reset_outputs",
                int'({load_ram, counter_ram, we_ram, mux_ram, mux_ram_addres, mux_ram_render,
                      register_head, register_eat_apple, count_size, busy, done, collided}), 0);
    @(negedge clock);
    restart = 1'b0;
    last_writes = writes;

    // Directed moves
    applyStimulus(1'b0, 1'b0, 6'd9);
    setSize(2);
    applyStimulus(1'b1, 1'b0, 6'd17);
    applyStimulus(1'b0, 1'b1, 6'd40);
    setSize(0);
    applyStimulus(1'b1, 1'b0, 6'd5);

    // start held for 20 cycles at size 1: two back-to-back moves
    setSize(1);
    @(negedge clock);
    new_head = 6'd33;
    start    = 1'b1;
    modelMove(cyc + 1, 1'b0, 1'b0);
    modelMove(cyc + 12, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    start = 1'b0;
    drain("held_start");

    // Growth at the cap boundary
    setSize(MAX_SIZE_DEF);
    applyStimulus(1'b1, 1'b0, 6'd21);
    setSize(MAX_SIZE_DEF - 1);
    applyStimulus(1'b1, 1'b0, 6'd22);

    // Randomized moves
    for (int t = 0; t < 16; t++) begin
      setSize(int'($urandom_range(0, 20)));
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    6'($urandom_range(0, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/snake_move_sequencer.md
Name: snake_move_sequencer

Overview:
- Control FSM that sequences one snake move through the snake-game datapath.
- On a `start` pulse from the main game control unit (issued when the play-time counter expires):
  - checks for wall collision;
  - shifts every body entry in the body RAM one address up, from tail to head;
  - writes the new head at address 0 and reloads the head register;
  - latches the eat-apple flag and grows the snake.
- Sits between the main control unit and the datapath strobes: RAM counter, RAM muxes, head register, size counter.

Parameters:
N, 6, address/position width (8x8 field)
MAX_SIZE, 14, size-counter value at which growth stops (used only with the optional feature)

Ports:
clock  in  1  system clock
restart  in  1  asynchronous active-high reset
start  in  1  one-cycle request to perform a move
end_move  in  1  RAM address counter is at zero
comeu_maca  in  1  new head equals apple position
wall_collision  in  1  new head leaves field (already gated by game mode)
size  in  N  current snake size counter value
load_ram  out  1  load RAM address counter with size
counter_ram  out  1  decrement RAM address counter
we_ram  out  1  RAM write enable
mux_ram  out  1  RAM data select: 1 = RAM q (shift), 0 = new head
mux_ram_addres  out  1  RAM address select: 1 = counter+1, 0 = counter
mux_ram_render  out  1  RAM address source: 1 = move path, 0 = render counter
register_head  out  1  head register enable
register_eat_apple  out  1  eat-apple flag register enable
count_size  out  1  increment size counter
busy  out  1  move in progress
done  out  1  one-cycle move-complete pulse
collided  out  1  one-cycle pulse: move aborted by wall collision

Behaviour:
- Reset:
  - `restart` high forces IDLE asynchronously.
  - All outputs 0, including mid-move; RAM contents are left as partially shifted.
- Body RAM read timing:
  - Read is registered: q is valid one cycle after the address is presented.
- Output defaults:
  - Every output is 0 unless listed for the current state.
  - `busy` = 1 in every state except IDLE.
  - `mux_ram_render` = 1 in every state except IDLE.
- States (Moore outputs), one cycle each unless looping:
  - IDLE: wait. `start` -> CHECK. A `start` seen while not in IDLE is ignored and never queued.
  - CHECK:
    - `register_eat_apple` = 1, capturing `comeu_maca`; internal `ate` flag <= `comeu_maca`.
    - `wall_collision` = 1 -> ABORT, otherwise -> LOAD.
  - ABORT: `collided` = 1, no RAM write -> IDLE.
  - LOAD: `load_ram` = 1 (counter <= size) -> READ.
  - READ: address = counter (`mux_ram_addres` = 0) -> WRITE.
  - WRITE:
    - `we_ram` = 1, `mux_ram` = 1, `mux_ram_addres` = 1, so RAM[c+1] <= RAM[c].
    - If `end_move` -> HEAD_WRITE.
    - Otherwise `counter_ram` = 1 in the same cycle -> READ.
  - HEAD_WRITE: `we_ram` = 1, `mux_ram` = 0, `mux_ram_addres` = 0 (counter = 0), so RAM[0] <= new head -> HEAD_READ.
  - HEAD_READ: address 0, no write -> HEAD_LATCH.
  - HEAD_LATCH: `register_head` = 1 (q = new head) -> DONE.
  - DONE: `done` = 1; `count_size` = `ate` -> IDLE.
- Latency:
  - With size = S, the loop visits addresses S down to 0 (S+1 entries, 2 cycles each).
  - `done` is high in cycle 2S+8 after the edge that samples `start`.
  - `collided` is high in cycle 2 after that edge.
- `end_move` is sampled only in WRITE. S = 0 gives a single READ/WRITE pair.
- `comeu_maca` and `wall_collision` are sampled only in CHECK; later changes are ignored.
- Growth happens after the shift, so the entry copied to address S+1 becomes the new tail.

Optional Feature:
- Macro `SGA_GROW_CAP_EN`.
- Defined: `count_size` in DONE = `ate` AND (size < MAX_SIZE); the size saturates at MAX_SIZE.
- Undefined: `count_size` = `ate`; saturation is left to the counter/win logic.

Decomposition:
- Shared package `sga_pkg` holds:
  - the state enumeration (4-bit encoding, IDLE = 0);
  - position width N = 6;
  - MAX_SIZE default.
- Single module; no sub-module is natural because all logic is one FSM plus the `ate` flag.

Test Plan:
- Reset mid-move: assert `restart` in READ at size 3 -> all outputs 0 immediately; next `start` runs a full move.
- No collision, no apple, size = 3:
  - `start` -> exactly 4 WRITE-state writes at addresses 4,3,2,1 plus one head write at address 0.
  - `done` in cycle 14; `count_size` = 0.
- Apple eaten, size = 2:
  - `comeu_maca` = 1 in CHECK -> `register_eat_apple` pulses in cycle 1.
  - `done` and `count_size` both high in cycle 12; size model becomes 3.
- Wall collision:
  - `wall_collision` = 1 in CHECK -> `collided` in cycle 2.
  - No `we_ram` ever high; `done` never asserted; `busy` low in cycle 3.
- `start` held high for 20 cycles at size 1 -> exactly one move (`done` once, in cycle 10), then a second move begins from IDLE.
- With `SGA_GROW_CAP_EN`, size = 14, apple eaten -> `done` pulses, `count_size` stays 0. Without the macro -> `count_size` = 1.
